// File: rtl/iob_acc_decim_pkg.sv
// Shared defaults and arithmetic rules for the integrate-and-decimate stage.
package iob_acc_decim_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ACC_W   = 32;
    localparam int DEF_DECIM_W = 8;

    // A programmed ratio of 0 behaves as 1 (pass-through).
    function automatic logic [31:0] eff_ratio(input logic [31:0] r);
        return (r == 32'd0) ? 32'd1 : r;
    endfunction

    // Signed add overflow: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic a_s, input logic b_s, input logic r_s);
        return (a_s == b_s) && (r_s != a_s);
    endfunction

endpackage

// File: rtl/iob_acc_decim_ctr.sv
// Decimation counter: counts accepted samples and flags the last one of a block.
module iob_acc_decim_ctr
    import iob_acc_decim_pkg::*;
#(
    parameter int DECIM_W = DEF_DECIM_W
) (
    input  logic               clk_i,
    input  logic               cke_i,
    input  logic               rst_n_i,
    input  logic               clear,
    input  logic               inc,
    input  logic [DECIM_W-1:0] decim_i,
    output logic               last
);

    logic [DECIM_W-1:0] cnt;
    logic [DECIM_W-1:0] reff;

    assign reff = DECIM_W'(eff_ratio(32'(decim_i)));
    // >= rather than == so a lowered ratio can never strand the counter past the end.
    assign last = (cnt >= reff - DECIM_W'(1));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt <= '0;
        end else if (cke_i) begin
            if (clear)
                cnt <= '0;
            else if (inc)
                cnt <= last ? '0 : cnt + DECIM_W'(1);
        end
    end

endmodule

// File: rtl/iob_acc_decim.sv
// Free-running CIC integrator that emits one accumulator snapshot every R accepted samples.
module iob_acc_decim
    import iob_acc_decim_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int DECIM_W = DEF_DECIM_W
) (
    input  logic               clk_i,
    input  logic               cke_i,
    input  logic               rst_n_i,
    input  logic               en_i,
    input  logic [DECIM_W-1:0] decim_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [DATA_W-1:0]  data_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [ACC_W-1:0]   data_o,
    output logic               overflow_o
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] data_ext;
    logic [ACC_W-1:0] sum;
    logic             last;
    logic             acc_en;
    logic             ovf_now;

    assign data_ext = ACC_W'($signed(data_i));
    assign sum      = acc + data_ext;
    assign ovf_now  = add_ovf(acc[ACC_W-1], data_ext[ACC_W-1], sum[ACC_W-1]);

    // Only the block-closing sample waits for the output slot; out_ready_i passes straight through.
    assign in_ready_o = en_i & (~last | ~out_valid_o | out_ready_i);
    assign acc_en     = in_valid_i & in_ready_o & cke_i;

    iob_acc_decim_ctr #(
        .DECIM_W (DECIM_W)
    ) u_ctr (
        .clk_i   (clk_i),
        .cke_i   (cke_i),
        .rst_n_i (rst_n_i),
        .clear   (~en_i),
        .inc     (acc_en),
        .decim_i (decim_i),
        .last    (last)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            acc         <= '0;
            overflow_o  <= 1'b0;
            out_valid_o <= 1'b0;
            data_o      <= '0;
        end else if (cke_i) begin
            if (!en_i) begin
                acc        <= '0;
                overflow_o <= 1'b0;
            end else if (acc_en) begin
                acc <= sum;
                if (ovf_now)
                    overflow_o <= 1'b1;
            end
            // Output register is left alone by en_i so a pending snapshot still drains.
            if (acc_en && last) begin
                out_valid_o <= 1'b1;
                data_o      <= sum;
            end else if (out_valid_o && out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule
